// File: rtl/spigot_digit_sequencer_if.sv
// Digit path between the spigot engine, the sequencer and the pin-level display.
// The slave side is the sequencer; the master side is the engine plus display.
interface spigot_digit_sequencer_if #(
    parameter int IDX_W = 12
);
    logic             core_start;
    logic [3:0]       core_digit;
    logic             core_valid;
    logic             core_ready;
    logic [3:0]       out_digit;
    logic             out_strobe;
    logic [IDX_W-1:0] out_index;

    modport slave (
        input  core_digit,
        input  core_valid,
        output core_start,
        output core_ready,
        output out_digit,
        output out_strobe,
        output out_index
    );

    modport master (
        output core_digit,
        output core_valid,
        input  core_start,
        input  core_ready,
        input  out_digit,
        input  out_strobe,
        input  out_index
    );
endinterface

// File: rtl/spigot_digit_sequencer.sv
// Sequencer between the spigot-e digit engine and the digit display.
// Starts the engine, buffers its digits in a small FIFO and releases them at a
// programmable pace, with pause / single-step control and a run-length bound.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | after reset, waiting for a start edge
//   S_START | one cycle: pulse core_start, clear run counters and FIFO
//   S_RUN   | accepting engine digits and emitting them at the pace
//   S_DRAIN | run length reached, emitting what is left in the FIFO
//   S_DONE  | all digits emitted, last digit held, waiting for a start edge
module spigot_digit_sequencer #(
    parameter int DEPTH      = 4,
    parameter int MAX_DIGITS = 1000,
    parameter int IDX_W      = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   cfg_start,
    input  logic                   cfg_pause,
    input  logic                   cfg_step,
    input  logic [3:0]             cfg_rate,
    spigot_digit_sequencer_if.slave bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             start_pulse;

    logic             start_q;
    logic             step_q;
    logic             start_edge;
    logic             step_edge;

    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;

    logic [IDX_W-1:0] accepted_q;
    logic [IDX_W-1:0] index_q;
    logic [3:0]       digit_q;
    logic             strobe_q;
    logic [15:0]      prescaler_q;
    logic             pending_q;
    logic             err_q;

    logic             active;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ready;
    logic             push;
    logic [15:0]      rate_mask;
    logic             tick;
    logic             pace_pop;
    logic             step_pop;
    logic             pop;

    assign start_edge = cfg_start & ~start_q;
    assign step_edge  = cfg_step & ~step_q;

    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign fifo_full  = (level_q == LVL_W'(DEPTH));
    assign fifo_empty = (level_q == '0);

    // ready depends only on the registered occupancy, so a full FIFO refuses
    // a push even in a cycle where it also pops; ena gates it so a frozen
    // sequencer never completes a handshake
    assign ready = ena && (state_q == S_RUN) && !cfg_pause && !fifo_full
                   && (accepted_q < IDX_W'(MAX_DIGITS));
    assign push  = ready && bus.core_valid;

    assign rate_mask = 16'((32'd1 << cfg_rate) - 32'd1);
    assign tick      = (cfg_rate == 4'd0) || ((prescaler_q & rate_mask) == rate_mask);

    // a missed tick on an empty FIFO is remembered in pending_q (at most one)
    assign pace_pop = active && !cfg_pause && (tick || pending_q) && !fifo_empty;
    assign step_pop = active && cfg_pause && step_edge && !fifo_empty;
    assign pop      = pace_pop || step_pop;

    // state register; frozen while ena is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // next-state decode and the engine start pulse
    always_comb begin
        state_d     = state_q;
        start_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                start_pulse = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (push && (accepted_q == IDX_W'(MAX_DIGITS - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !strobe_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start_edge) begin
                    state_d = S_START;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // edge history, FIFO, pacing and run counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            step_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            accepted_q  <= '0;
            index_q     <= '0;
            digit_q     <= '0;
            strobe_q    <= 1'b0;
            prescaler_q <= '0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (ena) begin
            start_q  <= cfg_start;
            step_q   <= cfg_step;
            strobe_q <= 1'b0;
            if (state_q == S_START) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                level_q     <= '0;
                accepted_q  <= '0;
                index_q     <= '0;
                prescaler_q <= '0;
                pending_q   <= 1'b0;
                err_q       <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= bus.core_digit;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                    accepted_q  <= accepted_q + IDX_W'(1);
                    if (bus.core_digit > 4'd9) begin
                        err_q <= 1'b1;
                    end
                end
                if (pop) begin
                    digit_q  <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    strobe_q <= 1'b1;
                    index_q  <= index_q + IDX_W'(1);
                end
                level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
                // pause holds both the prescaler and any pending tick
                if (active && !cfg_pause) begin
                    prescaler_q <= prescaler_q + 16'd1;
                    if (pace_pop) begin
                        pending_q <= 1'b0;
                    end else if (tick) begin
                        pending_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.core_start = start_pulse & ena;
    assign bus.core_ready = ready;
    assign bus.out_digit  = digit_q;
    assign bus.out_strobe = strobe_q & ena;
    assign bus.out_index  = index_q;

    assign fifo_level = level_q;
    assign busy       = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule
